// File: rtl/timer_ctrl.sv
// timer_ctrl: control FSM and hh:mm:ss counter for the lab timer.
// Steps time on tick_1hz in count-up (stopwatch) or count-down mode and
// raises alarm for ALARM_TICKS ticks when a countdown expires.
// Optional lap-hold display snapshot is built when TIMER_LAP_EN is defined.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | time editable via min/hour inc pulses, waiting for start
// RUN    | counting on each tick_1hz in the mode latched at start
// PAUSE  | time frozen, start resumes in the same mode
// DONE   | countdown reached 00:00:00, alarm on for ALARM_TICKS ticks
module timer_ctrl #(
  parameter int HOUR_MAX    = 23,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       rst_pulse,
  input  logic       start_pulse,
  input  logic       stop_pulse,
  input  logic       min_inc_pulse,
  input  logic       hour_inc_pulse,
  input  logic       cd_mode,
`ifdef TIMER_LAP_EN
  input  logic       lap_pulse,
  output logic       lap_hold,
`endif
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] state,
  output logic       running,
  output logic       alarm,
  output logic       mode_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int            CW         = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_TICKS - 1);
  localparam logic [4:0]    HOUR_TOP   = 5'(HOUR_MAX);

  state_t        st;
  logic [4:0]    hour_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;
  logic [CW-1:0] alarm_cnt;

  logic [4:0]    up_hour, dn_hour;
  logic [5:0]    up_min, dn_min, up_sec, dn_sec;
  logic          dn_zero, time_zero;

  // next count-up and count-down time values with carry/borrow
  always_comb begin
    up_sec  = sec_q + 6'd1;
    up_min  = min_q;
    up_hour = hour_q;
    if (sec_q == 6'd59) begin
      up_sec = 6'd0;
      up_min = min_q + 6'd1;
      if (min_q == 6'd59) begin
        up_min  = 6'd0;
        up_hour = (hour_q == HOUR_TOP) ? 5'd0 : hour_q + 5'd1;
      end
    end
    dn_sec  = sec_q - 6'd1;
    dn_min  = min_q;
    dn_hour = hour_q;
    if (sec_q == 6'd0) begin
      dn_sec = 6'd59;
      dn_min = min_q - 6'd1;
      if (min_q == 6'd0) begin
        dn_min  = 6'd59;
        dn_hour = (hour_q == 5'd0) ? HOUR_TOP : hour_q - 5'd1;
      end
    end
    dn_zero   = (dn_hour == 5'd0) && (dn_min == 6'd0) && (dn_sec == 6'd0);
    time_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
  end

`ifdef TIMER_LAP_EN
  logic [4:0] lap_hour;
  logic [5:0] lap_min, lap_sec;
`endif

  // control FSM, time counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      mode_q    <= 1'b0;
`ifdef TIMER_LAP_EN
      lap_hold  <= 1'b0;
      lap_hour  <= 5'd0;
      lap_min   <= 6'd0;
      lap_sec   <= 6'd0;
`endif
    end else if (rst_pulse) begin
      st        <= S_IDLE;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
`ifdef TIMER_LAP_EN
      lap_hold  <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (start_pulse) begin
            // a countdown from zero would expire instantly, so refuse it
            if (!(cd_mode && time_zero)) begin
              st      <= S_RUN;
              running <= 1'b1;
              mode_q  <= cd_mode;
            end
          end else begin
            if (min_inc_pulse)
              min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (hour_inc_pulse)
              hour_q <= (hour_q == HOUR_TOP) ? 5'd0 : hour_q + 5'd1;
          end
        end
        S_RUN: begin
          if (tick_1hz && mode_q && dn_zero) begin
            // expiry wins over a simultaneous stop
            hour_q    <= dn_hour;
            min_q     <= dn_min;
            sec_q     <= dn_sec;
            st        <= S_DONE;
            running   <= 1'b0;
            alarm     <= 1'b1;
            alarm_cnt <= '0;
`ifdef TIMER_LAP_EN
            lap_hold  <= 1'b0;
`endif
          end else begin
            if (tick_1hz) begin
              hour_q <= mode_q ? dn_hour : up_hour;
              min_q  <= mode_q ? dn_min  : up_min;
              sec_q  <= mode_q ? dn_sec  : up_sec;
            end
            if (stop_pulse) begin
              st      <= S_PAUSE;
              running <= 1'b0;
`ifdef TIMER_LAP_EN
              lap_hold <= 1'b0;
            end else if (lap_pulse) begin
              lap_hold <= ~lap_hold;
              lap_hour <= hour_q;
              lap_min  <= min_q;
              lap_sec  <= sec_q;
`endif
            end
          end
        end
        S_PAUSE: begin
          if (start_pulse) begin
            st      <= S_RUN;
            running <= 1'b1;
          end
        end
        S_DONE: begin
          if (start_pulse || stop_pulse) begin
            st        <= S_IDLE;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
          end else if (tick_1hz) begin
            if (alarm_cnt == ALARM_LAST) begin
              st        <= S_IDLE;
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_cnt + 1'b1;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state = st;

`ifdef TIMER_LAP_EN
  assign hour = lap_hold ? lap_hour : hour_q;
  assign min  = lap_hold ? lap_min  : min_q;
  assign sec  = lap_hold ? lap_sec  : sec_q;
`else
  assign hour = hour_q;
  assign min  = min_q;
  assign sec  = sec_q;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized pulses, checked against
// a reference model that keeps time as a single seconds count.
module tb_timer_ctrl;

  localparam int HOUR_MAX    = 23;
  localparam int ALARM_TICKS = 5;
  localparam int TMAX        = (HOUR_MAX + 1) * 3600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, rst_pulse = 1'b0, start_pulse = 1'b0, stop_pulse = 1'b0;
  logic       min_inc_pulse = 1'b0, hour_inc_pulse = 1'b0, cd_mode = 1'b0;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic [1:0] state;
  logic       running, alarm, mode_q;

  timer_ctrl #(.HOUR_MAX(HOUR_MAX), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .rst_pulse(rst_pulse),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .min_inc_pulse(min_inc_pulse), .hour_inc_pulse(hour_inc_pulse),
    .cd_mode(cd_mode), .hour(hour), .min(min), .sec(sec), .state(state),
    .running(running), .alarm(alarm), .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: t = total seconds, m_st 0 idle / 1 run / 2 pause / 3 done
  int t = 0, m_st = 0, m_acnt = 0;
  bit m_mq = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int dut_secs();
    return int'(hour) * 3600 + int'(min) * 60 + int'(sec);
  endfunction

  task automatic model_reset();
    t = 0; m_st = 0; m_acnt = 0; m_mq = 1'b0;
  endtask

  task automatic model_step(input bit rp, sp, pp, mi, hi, tk, cd);
    int h, m, s;
    if (rp) begin
      t = 0; m_st = 0; m_acnt = 0;
    end else begin
      case (m_st)
        0: if (sp) begin
             if (!(cd && t == 0)) begin m_st = 1; m_mq = cd; end
           end else if (mi || hi) begin
             h = t / 3600; m = (t / 60) % 60; s = t % 60;
             if (mi) m = (m + 1) % 60;
             if (hi) h = (h + 1) % (HOUR_MAX + 1);
             t = h * 3600 + m * 60 + s;
           end
        1: begin
             if (tk && m_mq && t == 1) begin
               t = 0; m_st = 3; m_acnt = 0;
             end else begin
               if (tk) t = m_mq ? t - 1 : (t + 1) % TMAX;
               if (pp) m_st = 2;
             end
           end
        2: if (sp) m_st = 1;
        default: if (sp || pp) begin
             m_st = 0; m_acnt = 0;
           end else if (tk) begin
             m_acnt++;
             if (m_acnt == ALARM_TICKS) begin m_st = 0; m_acnt = 0; end
           end
      endcase
    end
  endtask

  task automatic compare_all();
    check("hour", int'(hour), t / 3600);
    check("min", int'(min), (t / 60) % 60);
    check("sec", int'(sec), t % 60);
    check("state", int'(state), m_st);
    check("running", int'(running), int'(m_st == 1));
    check("alarm", int'(alarm), int'(m_st == 3));
    check("mode_q", int'(mode_q), int'(m_mq));
  endtask

  // one clock with the given pulses; cd_mode is taken from its current level
  task automatic cyc(input bit rp, sp, pp, mi, hi, tk);
    @(negedge clk);
    rst_pulse = rp; start_pulse = sp; stop_pulse = pp;
    min_inc_pulse = mi; hour_inc_pulse = hi; tick_1hz = tk;
    @(posedge clk);
    model_step(rp, sp, pp, mi, hi, tk, cd_mode);
    #1;
    compare_all();
    rst_pulse = 0; start_pulse = 0; stop_pulse = 0;
    min_inc_pulse = 0; hour_inc_pulse = 0; tick_1hz = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // count-up stopwatch
    cd_mode = 1'b0;
    cyc(0, 1, 0, 0, 0, 0);
    ticks(65);
    check("tp1_time", dut_secs(), 65);
    check("tp1_state", int'(state), 1);
    check("tp1_running", int'(running), 1);

    // editing wraps, countdown from zero refused
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 61; i++) cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0, 0, 1, 0);
    check("tp2_min", int'(min), 1);
    check("tp2_hour", int'(hour), 0);
    cyc(1, 0, 0, 0, 0, 0);
    cd_mode = 1'b1;
    cyc(0, 1, 0, 0, 0, 0);
    check("tp2_cd_zero_start", int'(state), 0);

    // countdown from 00:01:00 through alarm
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(59);
    check("tp3_time59", dut_secs(), 1);
    ticks(1);
    check("tp3_time0", dut_secs(), 0);
    check("tp3_done", int'(state), 3);
    check("tp3_alarm", int'(alarm), 1);
    ticks(ALARM_TICKS - 1);
    check("tp3_still_done", int'(state), 3);
    ticks(1);
    check("tp3_idle", int'(state), 0);
    check("tp3_alarm_off", int'(alarm), 0);

    // tick+stop together, resume keeps the latched mode
    cd_mode = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(10);
    cyc(0, 0, 1, 0, 0, 1);
    check("tp4_time", dut_secs(), 11);
    check("tp4_pause", int'(state), 2);
    cd_mode = 1'b1;
    cyc(0, 1, 0, 0, 0, 0);
    check("tp4_resume", int'(state), 1);
    check("tp4_mode", int'(mode_q), 0);
    ticks(2);
    check("tp4_time2", dut_secs(), 13);

    // day wrap and reset-beats-start
    cd_mode = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < HOUR_MAX; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(59);
    check("tp5_max", dut_secs(), HOUR_MAX * 3600 + 59 * 60 + 59);
    ticks(1);
    check("tp5_wrap", dut_secs(), 0);
    check("tp5_run", int'(state), 1);
    cyc(1, 1, 0, 0, 0, 0);
    check("tp5_rst_start", int'(state), 0);

    // asynchronous reset mid-run
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized pulses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) cd_mode = ~cd_mode;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
